// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and feeds decode through an output register backed by a one-entry skid buffer.
package if_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pcplus4;
   } if_id_t;
endpackage

module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           redirect_valid,
   input  logic [31:0]    redirect_pc,
   output logic           imem_req_valid,
   input  logic           imem_req_ready,
   output logic [31:0]    imem_addr,
   input  logic           imem_rsp_valid,
   input  logic [31:0]    imem_rsp_data,
   output logic           id_valid,
   input  logic           id_ready,
   output if_pkg::if_id_t out,
   output logic [31:0]    instr
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high. An unaccepted imem request keeps its address and valid stable unless a
   // redirect or reset intervenes; id_valid/out/instr hold while id_ready is low.
   logic [31:0] r_pc;
   logic [31:0] r_req_pc;
   logic        r_outstanding;
   logic        r_drop;
   logic        r_id_valid;
   logic [31:0] r_out_pc;
   logic [31:0] r_out_pcplus4;
   logic [31:0] r_instr;
   logic        r_skid_valid;
   logic [31:0] r_skid_pc;
   logic [31:0] r_skid_instr;

   logic w_rsp_take;
   logic w_hold;
   logic w_req_valid;
   logic w_fire;

   assign w_rsp_take = imem_rsp_valid && r_outstanding && !r_drop;
   assign w_hold     = r_id_valid && !id_ready;

   // A response that lands in the skid this cycle leaves no room for another
   // one, so no follow-up request may be sent alongside it.
   assign w_req_valid = !reset && !redirect_valid && !r_skid_valid
                        && !(w_hold && w_rsp_take)
                        && (!r_outstanding || imem_rsp_valid);
   assign w_fire      = w_req_valid && imem_req_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_req_pc      <= 32'd0;
         r_outstanding <= 1'b0;
         r_drop        <= 1'b0;
         r_id_valid    <= 1'b0;
         r_out_pc      <= 32'd0;
         r_out_pcplus4 <= 32'd0;
         r_instr       <= 32'd0;
         r_skid_valid  <= 1'b0;
         r_skid_pc     <= 32'd0;
         r_skid_instr  <= 32'd0;
      end else if (redirect_valid) begin
         r_pc         <= redirect_pc;
         r_id_valid   <= 1'b0;
         r_skid_valid <= 1'b0;
         if (imem_rsp_valid) begin
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
         end else if (r_outstanding) begin
            r_drop <= 1'b1;
         end
      end else begin
         if (w_fire) begin
            r_req_pc      <= r_pc;
            r_pc          <= r_pc + 32'd4;
            r_outstanding <= 1'b1;
         end else if (imem_rsp_valid) begin
            r_outstanding <= 1'b0;
         end
         if (imem_rsp_valid) begin
            r_drop <= 1'b0;
         end

         if (!w_hold) begin
            if (r_skid_valid) begin
               r_id_valid    <= 1'b1;
               r_out_pc      <= r_skid_pc;
               r_out_pcplus4 <= r_skid_pc + 32'd4;
               r_instr       <= r_skid_instr;
               r_skid_valid  <= w_rsp_take;
            end else if (w_rsp_take) begin
               r_id_valid    <= 1'b1;
               r_out_pc      <= r_req_pc;
               r_out_pcplus4 <= r_req_pc + 32'd4;
               r_instr       <= imem_rsp_data;
            end else begin
               r_id_valid <= 1'b0;
            end
         end else if (w_rsp_take) begin
            r_skid_valid <= 1'b1;
         end

         // Skid payload is only meaningful while r_skid_valid is set.
         if (w_rsp_take) begin
            r_skid_pc    <= r_req_pc;
            r_skid_instr <= imem_rsp_data;
         end
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_addr      = r_pc;
   assign id_valid       = r_id_valid;
   assign out            = '{pc: r_out_pc, pcplus4: r_out_pcplus4};
   assign instr          = r_instr;

endmodule
